// File: rtl/sseg_scan_driver_pkg.sv
// Shared definitions for the seven-segment scan driver: active-low segment codes,
// the nibble-to-segment decoder, the converter state type and the overflow limit helper.
package sseg_pkg;

    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b1111110;

    typedef enum logic {IDLE, CONV} state_t;

    function automatic logic [6:0] seg_code(input logic [3:0] nib);
        logic [6:0] code;
        case (nib)
            4'd0:    code = SEG_0;
            4'd1:    code = SEG_1;
            4'd2:    code = SEG_2;
            4'd3:    code = SEG_3;
            4'd4:    code = SEG_4;
            4'd5:    code = SEG_5;
            4'd6:    code = SEG_6;
            4'd7:    code = SEG_7;
            4'd8:    code = SEG_8;
            4'd9:    code = SEG_9;
            default: code = SEG_BLANK;
        endcase
        return code;
    endfunction

    // Largest value that fits in n_digits decimal digits (10^n - 1).
    function automatic logic [63:0] max_value(input int n_digits);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < n_digits; i++) begin
            p = p * 64'd10;
        end
        return p - 64'd1;
    endfunction

endpackage

// File: rtl/sseg_scan_driver_bin2bcd_seq.sv
// Iterative shift-add-3 binary-to-BCD converter: one bit per clock, WIDTH clocks per value.
// o_done pulses on the final iteration, in the same cycle o_bcd takes the new result.
module bin2bcd_seq
    import sseg_pkg::*;
#(
    parameter int WIDTH    = 14,
    parameter int N_DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_start,
    input  logic [WIDTH-1:0]      i_value,
    output logic                  o_ready,
    output logic                  o_done,
    output logic [4*N_DIGITS-1:0] o_bcd
);

    localparam int BCD_W = 4 * N_DIGITS;
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t             r_state;
    logic [WIDTH-1:0]   r_shift;
    logic [BCD_W-1:0]   r_acc;
    logic [BCD_W-1:0]   r_result;
    logic [CNT_W-1:0]   r_cnt;
    logic [BCD_W-1:0]   w_adj;
    logic [BCD_W-1:0]   w_acc_next;
    logic               w_last;

    genvar gi;
    generate
        for (gi = 0; gi < N_DIGITS; gi++) begin : g_adj
            assign w_adj[4*gi +: 4] = (r_acc[4*gi +: 4] >= 4'd5) ? r_acc[4*gi +: 4] + 4'd3
                                                                  : r_acc[4*gi +: 4];
        end
    endgenerate

    // Carry out of the top nibble falls off here; overflow is flagged separately.
    assign w_acc_next = {w_adj[BCD_W-2:0], r_shift[WIDTH-1]};
    assign w_last     = (r_state == CONV) && (r_cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_shift  <= '0;
            r_acc    <= '0;
            r_result <= '0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_shift <= i_value;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        r_state <= CONV;
                    end
                end
                CONV: begin
                    r_acc   <= w_acc_next;
                    r_shift <= r_shift << 1;
                    r_cnt   <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_result <= w_acc_next;
                        r_state  <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_ready = (r_state == IDLE);
    assign o_done  = w_last;
    assign o_bcd   = r_result;

endmodule

// File: rtl/sseg_scan_driver.sv
// Multiplexed seven-segment display driver: sequential BCD conversion of a loaded value,
// then round-robin scan of the digits with leading-zero blanking and overflow dashes.
module sseg_scan_driver
    import sseg_pkg::*;
#(
    parameter int N_DIGITS = 4,
    parameter int WIDTH    = 14,
    parameter int SCAN_DIV = 50000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [WIDTH-1:0]    value,
    input  logic                load,
    output logic                ready,
    output logic                overflow,
    output logic [6:0]          sseg,
    output logic [N_DIGITS-1:0] an
);

    localparam logic [63:0] MAX_VALUE = max_value(N_DIGITS);
    localparam int          PRE_W     = $clog2(SCAN_DIV);
    localparam int          K_W       = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    logic                  w_ready;
    logic                  w_start;
    logic                  w_done;
    logic                  w_too_big;
    logic [4*N_DIGITS-1:0] w_bcd;
    logic [N_DIGITS-1:0]   w_nib_zero;
    logic [N_DIGITS-1:0]   w_zero_from;
    logic [3:0]            w_nib;
    logic [6:0]            w_seg_sel;

    logic                  r_ovf_pending;
    logic                  r_overflow;
    logic [PRE_W-1:0]      r_presc;
    logic [K_W-1:0]        r_k;
    logic [6:0]            r_sseg;
    logic [N_DIGITS-1:0]   r_an;

    assign w_start   = load && w_ready;
    assign w_too_big = 64'(value) > MAX_VALUE;

    bin2bcd_seq #(
        .WIDTH    (WIDTH),
        .N_DIGITS (N_DIGITS)
    ) u_bin2bcd (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_start (w_start),
        .i_value (value),
        .o_ready (w_ready),
        .o_done  (w_done),
        .o_bcd   (w_bcd)
    );

    // w_zero_from[i]: every nibble from i up to the most significant is zero.
    genvar gi;
    generate
        for (gi = 0; gi < N_DIGITS; gi++) begin : g_blank
            assign w_nib_zero[gi]  = (w_bcd[4*gi +: 4] == 4'd0);
            assign w_zero_from[gi] = &w_nib_zero[N_DIGITS-1:gi];
        end
    endgenerate

    always_comb begin
        w_nib     = w_bcd[4*r_k +: 4];
        w_seg_sel = seg_code(w_nib);
        if (r_overflow) begin
            w_seg_sel = SEG_DASH;
        end else if ((r_k != '0) && w_zero_from[r_k]) begin
            w_seg_sel = SEG_BLANK;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf_pending <= 1'b0;
            r_overflow    <= 1'b0;
            r_presc       <= '0;
            r_k           <= '0;
            r_sseg        <= SEG_BLANK;
            r_an          <= '1;
        end else begin
            if (w_start) begin
                r_ovf_pending <= w_too_big;
            end
            if (w_done) begin
                r_overflow <= r_ovf_pending;
            end
            if (r_presc == PRE_W'(SCAN_DIV - 1)) begin
                r_presc <= '0;
                r_k     <= (r_k == K_W'(N_DIGITS - 1)) ? '0 : r_k + 1'b1;
            end else begin
                r_presc <= r_presc + 1'b1;
            end
            r_an   <= ~(N_DIGITS'(1) << r_k);
            r_sseg <= w_seg_sel;
        end
    end

    assign ready    = w_ready;
    assign overflow = r_overflow;
    assign sseg     = r_sseg;
    assign an       = r_an;

endmodule

// File: doc/sseg_scan_driver.md
# sseg_scan_driver

Parametrised multi-digit seven-segment display controller. It accepts an unsigned binary value through a ready/load handshake and converts it to BCD sequentially (shift-add-3). It then time-multiplexes the digits onto one shared active-low segment bus with per-digit active-low enables, blanking leading zeros and flagging values that do not fit. It sits between any counter/datapath result and the board display pins, replacing per-digit combinational decoders.

## Interface
- `N_DIGITS`, default 4, number of multiplexed digits (1..8).
- `WIDTH`, default 14, bit width of `value`.
- `SCAN_DIV`, default 50000, clock cycles each digit stays enabled (≥2).
- `clk` in 1: single clock, all state on rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `value` in WIDTH: unsigned binary value to display.
- `load` in 1: request; value captured when `load && ready`.
- `ready` out 1: high when idle and able to accept a load.
- `overflow` out 1: high while the displayed value exceeds 10^N_DIGITS − 1.
- `sseg` out 7: segments {a,b,c,d,e,f,g} = bits [6:0], active-low (0 = lit).
- `an` out N_DIGITS: digit enables, active-low, one-hot-zero; bit 0 = least significant (rightmost) digit.

## Operation
- Segment codes (active-low, a..g):
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100.
  - 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100.
  - blank=1111111; dash=1111110 (g only).
- States: IDLE (ready=1), CONV (ready=0).
  - IDLE→CONV on `load && ready`: capture `value`; clear the BCD accumulator of 4·N_DIGITS bits; set overflow_pending = (value > 10^N_DIGITS − 1).
  - CONV runs exactly WIDTH iterations. Each iteration adds 3 to every BCD nibble ≥5, then shifts left one bit, bringing in the next MSB of the captured value.
  - CONV→IDLE after the last iteration: the display register takes the accumulator; `overflow` takes overflow_pending.
- A `load` while in CONV is ignored; no queueing.
- Scan: a prescaler counts 0..SCAN_DIV−1. At its terminal count, digit index k advances (N_DIGITS−1 wraps to 0). `an` = all ones except bit k low.
- Segment selection for digit k:
  - If `overflow`: dash on every digit.
  - Else if k>0 and nibbles k..N_DIGITS−1 are all zero: blank.
  - Else: code of nibble k.
  - Digit 0 is never blanked, so value 0 shows "0".
- Width rule: the accumulator carry out of the top nibble is discarded. Displayed digits are meaningless when `overflow`=1, which is why dashes are forced.

## Timing
- Reset values:
  - `ready`=1, `overflow`=0, `sseg`=1111111, `an`=all ones.
  - Display register 0, prescaler 0, k=0, state IDLE.
- `sseg` and `an` are registered. The first rising edge after `rst_n` release drives k=0, i.e. `an` bit 0 low showing "0".
- Load accepted at edge E: `ready`=0 from E. The display register and `overflow` update, and `ready` returns to 1, at edge E+WIDTH. Another load is accepted at E+WIDTH.
- Display updates take effect on the next cycle. They do not disturb the scan phase (prescaler and k are unaffected).
- `sseg` and `an` change on the same edge, so there is no cycle with a stale digit pattern.
- `rst_n` asserted mid-conversion aborts immediately: outputs return to reset values and the pending value is discarded.

## Structure
- Shared package `sseg_pkg`:
  - Segment constants SEG_0..SEG_9, SEG_BLANK, SEG_DASH.
  - Function mapping a 4-bit nibble to its 7-bit code (non-BCD nibbles map to SEG_BLANK).
  - State enum {IDLE, CONV}.
- One natural sub-module: `bin2bcd_seq`, the iterative converter with start/done and parameters WIDTH, N_DIGITS.
- Scan, blanking and output registers stay in the top module.

## Test plan
Bench parameters: N_DIGITS=4, WIDTH=14, SCAN_DIV=4.
- Reset held, then released → `an`=1111, `sseg`=1111111, `ready`=1, `overflow`=0 during reset. First post-release cycle: `an`=1110, `sseg`=0000001.
- Load 1234 at edge E → `ready` low for 14 cycles, high at E+14. The scan then shows, 4 cycles per digit:
  - `an`=1110 with `sseg`=1001100.
  - `an`=1101 with 0000110.
  - `an`=1011 with 0010010.
  - `an`=0111 with 1001111.
- Load 7, then load 0 → digits 1–3 show 1111111. Digit 0 shows 0001111, then 0000001.
- Load 10000 → `overflow`=1 and all four digits show 1111110. Then load 9999 → `overflow`=0 and every digit shows 0000100.
- Load 42 with a second load of 99 three cycles later → second load ignored; display 42 (digit1 1001100, digit0 0010010; digits 2–3 blank).
- Load 555, assert `rst_n` low 5 cycles into conversion → immediate reset values. After release the display shows "0" and `ready`=1.
- Prescaler check: `an` changes exactly every 4 cycles, and k wraps from 3 to 0.
